// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, one full-adder cell reused LSB-first over WIDTH cycles.
// Optional subtract mode (input sub_i) is enabled by defining SERIAL_ADD_SUB_EN.
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] r_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [WIDTH-1:0] b_load_d;
  logic             carry_init_d;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_sh_d;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as A + ~B + 1; the incoming carry is ignored.
  assign b_load_d     = sub_i ? ~b_i : b_i;
  assign carry_init_d = sub_i ? 1'b1 : cin_i;
`else
  assign b_load_d     = b_i;
  assign carry_init_d = cin_i;
`endif

  assign fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  // New sum bit enters at the top; after WIDTH shifts bit 0 holds the LSB result.
  assign r_sh_d = {fa_sum, r_sh_q};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_load_d;
            carry_q <= carry_init_d;
            r_sh_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          r_sh_q  <= r_sh_d[WIDTH-1:1];
          carry_q <= fa_cout;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= r_sh_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

`default_nettype wire
